// File: rtl/io_buffer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// io_buffer_pkg : shared FSM encoding and sizing helpers for io_buffer controllers
// Rev 1.0
// ----------------------------------------------------------------------------
package io_buffer_pkg;

  localparam int SKID_DEPTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } drain_state_t;

  function automatic int log2_ceil(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_skid_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// io_skid_fifo : small circular FIFO holding popped words until the stream takes them
// Rev 1.0
// ----------------------------------------------------------------------------
module io_skid_fifo
  import io_buffer_pkg::*;
#(
  parameter  int DEPTH      = SKID_DEPTH,
  parameter  int DATA_WIDTH = 16,
  localparam int PTR_W      = log2_ceil(DEPTH),
  localparam int CNT_W      = log2_ceil(DEPTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] head,
  output logic [CNT_W-1:0]      count
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (rd_en) rd_ptr <= ptr_next(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/io_buffer_drain.sv
`default_nettype none
// ----------------------------------------------------------------------------
// io_buffer_drain : pops i_len words from the stack buffer and streams them out
// Rev 1.0
// ----------------------------------------------------------------------------
module io_buffer_drain
  import io_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int STACK_SIZE = 256,
  parameter int LEN_WIDTH  = 9
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [LEN_WIDTH-1:0]  i_len,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic                  o_pop_cmd,
  input  logic [DATA_WIDTH-1:0] i_pop_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_last
);

  localparam int CNT_W = log2_ceil(SKID_DEPTH + 1);

  drain_state_t          state;
  logic [LEN_WIDTH-1:0]  pops_left;
  logic [LEN_WIDTH-1:0]  words_left;
  logic                  inflight;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W:0]        outstanding;
  logic                  xfer;

  // Credit check uses registered state only, so ready never reaches the pop strobe.
  assign outstanding = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
  assign o_pop_cmd   = (state == ST_RUN) && (pops_left != '0)
                     && (outstanding < (CNT_W + 1)'(SKID_DEPTH));

  assign o_valid = (fifo_count != '0);
  assign o_last  = o_valid && (words_left == LEN_WIDTH'(1));
  assign xfer    = o_valid && i_ready;

  io_skid_fifo #(
    .DEPTH      (SKID_DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .wr_en   (inflight),
    .wr_data (i_pop_data),
    .rd_en   (xfer),
    .head    (o_data),
    .count   (fifo_count)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      pops_left  <= '0;
      words_left <= '0;
      inflight   <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      inflight <= o_pop_cmd;
      o_done   <= 1'b0;
      o_err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            if (i_len == '0) begin
              state  <= ST_DONE;
              o_busy <= 1'b1;
              o_done <= 1'b1;
            end else if (i_len > LEN_WIDTH'(STACK_SIZE)) begin
              o_err <= 1'b1;
            end else begin
              state      <= ST_RUN;
              o_busy     <= 1'b1;
              pops_left  <= i_len;
              words_left <= i_len;
            end
          end
        end
        ST_RUN: begin
          if (o_pop_cmd) pops_left <= pops_left - 1'b1;
          if (xfer) begin
            words_left <= words_left - 1'b1;
            if (words_left == LEN_WIDTH'(1)) begin
              state  <= ST_DONE;
              o_done <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_io_buffer_drain.sv
`default_nettype none
// tb_io_buffer_drain : table of drain vectors against a registered stack-buffer model,
// plus hand sequences for reset behaviour.
module tb_io_buffer_drain;

  localparam int DW   = 16;
  localparam int SS   = 256;
  localparam int LW   = 9;
  localparam int SKIP = -99;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic          ready = 1'b0;
  logic          busy, done, err, pop_cmd, valid, last;
  logic [DW-1:0] pop_data = '0;
  logic [DW-1:0] data;

  io_buffer_drain #(
    .DATA_WIDTH (DW),
    .STACK_SIZE (SS),
    .LEN_WIDTH  (LW)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_len      (len),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err),
    .o_pop_cmd  (pop_cmd),
    .i_pop_data (pop_data),
    .o_data     (data),
    .o_valid    (valid),
    .i_ready    (ready),
    .o_last     (last)
  );

  always #5 clk = ~clk;

  // Stack buffer model: one-cycle registered pop output.
  logic [DW-1:0] stack [512];
  int            sp = 0;
  int            load_n = 0;
  logic          load = 1'b0;

  always @(posedge clk) begin
    if (load) sp <= load_n;
    else if (pop_cmd) begin
      if (sp > 0) begin
        pop_data <= stack[sp-1];
        sp       <= sp - 1;
      end else pop_data <= 16'hDEAD;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got unexpected event, expected none", name);
  endtask

  // Stream monitor, sampled on the falling edge.
  int            cycle = 0, pops = 0, xfers = 0, dones = 0, errs = 0, busy_cycles = 0;
  int            first_valid = -1, done_at = -1, cur_len = 0;
  bit            mon_en = 1'b0, prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [DW-1:0] exp_word;
  logic [DW-1:0] exp_q [$];

  always @(negedge clk) begin
    if (mon_en) begin
      if (pop_cmd) pops++;
      if (busy) busy_cycles++;
      if (err) errs++;
      if (done) begin
        dones++;
        done_at = cycle;
      end
      if (valid && first_valid < 0) first_valid = cycle;
      check("outstanding_le_3", 32'((pops - xfers) <= 3), 32'd1);
      if (prev_stall) begin
        check("stall_valid", 32'(valid), 32'd1);
        check("stall_data", 32'(data), 32'(prev_data));
      end
      if (valid) check("last", 32'(last), 32'((cur_len - xfers) == 1));
      else check("last_idle", 32'(last), 32'd0);
      if (valid && ready) begin
        if (exp_q.size() == 0) fail_now("extra_transfer");
        else begin
          exp_word = exp_q.pop_front();
          check("data", 32'(data), 32'(exp_word));
        end
        xfers++;
      end
      prev_stall = valid && !ready;
      prev_data  = data;
    end
  end

  typedef struct {
    int len;
    int base;
    int stall_from;
    int stall_to;
    bit rnd;
    int restart_at;
    int exp_pops;
    int exp_xfers;
    int exp_dones;
    int exp_errs;
    int exp_first_valid;
    int exp_done_at;
  } vec_t;

  vec_t vecs [9];

  function automatic logic ready_for(input vec_t v, input int c);
    if (v.rnd) return logic'($urandom & 1);
    if (c >= v.stall_from && c <= v.stall_to) return 1'b0;
    return 1'b1;
  endfunction

  task automatic load_stack(input int n, input int base);
    for (int i = 0; i < n; i++) stack[i] = DW'(base + i + 1);
    exp_q.delete();
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(stack[i]);
    load_n = n;
    load   = 1'b1;
    @(posedge clk); #1;
    load   = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int budget;
    bit timed_out;
    load_stack((v.len > SS) ? 0 : v.len, v.base);
    pops = 0; xfers = 0; dones = 0; errs = 0; busy_cycles = 0;
    first_valid = -1; done_at = -1; cur_len = v.len; prev_stall = 1'b0; cycle = 0;
    start = 1'b1;
    len   = LW'(v.len);
    ready = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    cycle  = 1;
    mon_en = 1'b1;
    budget = 4 * v.len + 60;
    timed_out = 1'b1;
    for (int n = 0; n < budget; n++) begin
      ready = ready_for(v, cycle);
      if (cycle == v.restart_at) begin
        start = 1'b1;
        len   = LW'(5);
      end else start = 1'b0;
      @(posedge clk); #1;
      cycle++;
      if ((v.exp_dones == 0) ? (cycle >= 10) : (dones > 0 && cycle >= done_at + 3)) begin
        timed_out = 1'b0;
        break;
      end
    end
    mon_en = 1'b0;
    start  = 1'b0;
    ready  = 1'b0;
    if (timed_out) fail_now("drain_timeout");
    check("pops", 32'(pops), 32'(v.exp_pops));
    check("transfers", 32'(xfers), 32'(v.exp_xfers));
    check("done_pulses", 32'(dones), 32'(v.exp_dones));
    check("err_pulses", 32'(errs), 32'(v.exp_errs));
    check("words_left_over", 32'(exp_q.size()), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    if (v.exp_first_valid != SKIP) check("first_valid_cycle", 32'(first_valid), 32'(v.exp_first_valid));
    if (v.exp_done_at != SKIP) begin
      check("done_cycle", 32'(done_at), 32'(v.exp_done_at));
      check("busy_cycles", 32'(busy_cycles), 32'((v.exp_done_at < 0) ? 0 : v.exp_done_at));
    end
  endtask

  initial begin
    //        len  base     sf  st  rnd rs  pops xfer dn er fv  done
    vecs[0] = '{4,   'h0,    0, -1, 0, -1, 4,   4,   1, 0, 3,  7};
    vecs[1] = '{8,   'h100,  3, 10, 0, -1, 8,   8,   1, 0, 3,  19};
    vecs[2] = '{0,   'h0,    0, -1, 0, -1, 0,   0,   1, 0, -1, 1};
    vecs[3] = '{257, 'h0,    0, -1, 0, -1, 0,   0,   0, 1, -1, -1};
    vecs[4] = '{6,   'h200,  0, -1, 0, 3,  6,   6,   1, 0, 3,  9};
    vecs[5] = '{1,   'h300,  0, -1, 0, -1, 1,   1,   1, 0, 3,  4};
    vecs[6] = '{3,   'h400,  1, 20, 0, -1, 3,   3,   1, 0, 3,  24};
    vecs[7] = '{256, 'h1000, 0, -1, 1, -1, 256, 256, 1, 0, 3,  SKIP};
    vecs[8] = '{2,   'h600,  0, -1, 0, -1, 2,   2,   1, 0, 3,  5};

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_pop", 32'(pop_cmd), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_last", 32'(last), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset asserted mid-drain: everything drops without waiting for a clock.
    load_stack(6, 'h500);
    ready = 1'b1;
    start = 1'b1;
    len   = LW'(6);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("pre_reset_valid", 32'(valid), 32'd1);
    check("pre_reset_pop", 32'(pop_cmd), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(valid), 32'd0);
    check("async_rst_pop", 32'(pop_cmd), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_data", 32'(data), 32'd0);
    check("async_rst_last", 32'(last), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("post_rst_idle", 32'({valid, pop_cmd, busy, done}), 32'd0);
    end
    @(posedge clk); #1;
    run_vec(vecs[8]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
